// File: rtl/nios_core_vga_pll_ctrl.sv
// Power-up sequencer for the VGA pixel PLL: pulses pll_rst, waits for lock, debounces it, then releases vga_rst.
// Optional RUN-state lock-loss counter is enabled by defining VGA_PLL_CTRL_LOCK_LOSS_CNT_EN.
module nios_core_vga_pll_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       vga_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retries_q, retries_d;
  logic [1:0]    sync_q, sync_d;
  logic          pll_rst_q, pll_rst_d;
  logic          vga_rst_q, vga_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          locked_s;

  assign locked_s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], pll_locked};
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    if (restart) begin
      state_d   = ST_PLL_RESET;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RESET: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          cnt_d = cnt_q + CW'(1);
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            cnt_d = '0;
            if (retries_q == 4'(MAX_RETRIES)) begin
              state_d = ST_FAIL;
            end else begin
              state_d   = ST_PLL_RESET;
              retries_d = retries_q + 4'd1;
            end
          end
        end
        ST_STABLE: begin
          cnt_d = cnt_q + CW'(1);
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            retries_d = '0;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_PLL_RESET;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_FAIL;
        end
      endcase
    end
    // Outputs decode the next state so they change on the same edge as the FSM.
    pll_rst_d = (state_d == ST_PLL_RESET);
    vga_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_PLL_RESET;
      cnt_q     <= '0;
      retries_q <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      vga_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      sync_q    <= sync_d;
      pll_rst_q <= pll_rst_d;
      vga_rst_q <= vga_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst = pll_rst_q;
  assign vga_rst = vga_rst_q;
  assign ready   = ready_q;
  assign fail    = fail_q;
  assign state   = state_q;

`ifdef VGA_PLL_CTRL_LOCK_LOSS_CNT_EN
  logic [7:0] loss_q, loss_d;

  // A restart in the same cycle wins, so that transition is not a lock loss.
  always_comb begin
    loss_d = loss_q;
    if ((state_q == ST_RUN) && !restart && !locked_s && (loss_q != 8'hFF)) begin
      loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_nios_core_vga_pll_ctrl.sv
// Self-checking bench for nios_core_vga_pll_ctrl: directed sequences plus random lock/restart/reset
// traffic, all compared cycle by cycle against a phase/duration reference model.
module tb_nios_core_vga_pll_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 8;
  localparam int STABLE_CYCLES = 6;
  localparam int MAX_RETRIES   = 2;

  logic       refclk = 1'b0;
  logic       rst, pll_locked, restart;
  logic       pll_rst, vga_rst, ready, fail;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, cycles spent in phase, retry count, loss count,
  // and the two most recent pll_locked samples (the synchronizer delay line).
  int m_phase, m_time, m_retry, m_loss;
  bit lk_hist [2];

  nios_core_vga_pll_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .vga_rst      (vga_rst),
    .ready        (ready),
    .fail         (fail),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int loss_expected();
`ifdef VGA_PLL_CTRL_LOCK_LOSS_CNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  task automatic enter_phase(input int p);
    m_phase = p;
    m_time  = 0;
  endtask

  // Advance the model by one refclk edge using the inputs currently applied.
  task automatic model_step();
    bit ls;
    if (rst) begin
      enter_phase(0);
      m_retry = 0;
      m_loss  = 0;
      lk_hist[0] = 1'b0;
      lk_hist[1] = 1'b0;
    end else begin
      ls = lk_hist[1];
      lk_hist[1] = lk_hist[0];
      lk_hist[0] = pll_locked;
      if (restart) begin
        enter_phase(0);
        m_retry = 0;
      end else begin
        case (m_phase)
          0: begin
            m_time++;
            if (m_time == RST_CYCLES) enter_phase(1);
          end
          1: begin
            if (ls) enter_phase(2);
            else begin
              m_time++;
              if (m_time == LOCK_TIMEOUT) begin
                if (m_retry == MAX_RETRIES) enter_phase(4);
                else begin
                  m_retry++;
                  enter_phase(0);
                end
              end
            end
          end
          2: begin
            if (!ls) enter_phase(1);
            else begin
              m_time++;
              if (m_time == STABLE_CYCLES) begin
                enter_phase(3);
                m_retry = 0;
              end
            end
          end
          3: begin
            if (!ls) begin
              enter_phase(0);
              if (m_loss < 255) m_loss++;
            end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("state", state, m_phase);
    check_eq("pll_rst", pll_rst, (m_phase == 0) ? 1 : 0);
    check_eq("vga_rst", vga_rst, (m_phase != 3) ? 1 : 0);
    check_eq("ready", ready, (m_phase == 3) ? 1 : 0);
    check_eq("fail_out", fail, (m_phase == 4) ? 1 : 0);
    check_eq("lock_loss_cnt", lock_loss_cnt, loss_expected());
  endtask

  task automatic step();
    model_step();
    @(posedge refclk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    restart = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && state !== 3'(target); k++) step();
    check_eq(tag, state, target);
  endtask

  task automatic measure_pll_rst_run(output int run);
    run = 0;
    for (int k = 0; k < 40 && pll_rst === 1'b1; k++) begin
      run++;
      step();
    end
  endtask

  initial begin
    int run, pulses, wl_entries, first_ready, cyc;
    logic [2:0] prev_st;

    rst = 1'b1;
    restart = 1'b0;
    pll_locked = 1'b0;

    // Reset values and first lock-up: lock asserted during cycle 6 after release.
    do_reset();
    check_eq("reset_pll_rst", pll_rst, 1);
    first_ready = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == 6) pll_locked = 1'b1;
      step();
      if (ready === 1'b1 && first_ready < 0) begin
        first_ready = i + 1;
        check_eq("ready_vga_rst", vga_rst, 0);
      end
    end
    // lock seen in cycle 6, +2 synchronizer, +1 to enter STABLE, then STABLE_CYCLES.
    check_eq("first_ready_cycle", first_ready, 6 + 2 + 1 + STABLE_CYCLES);

    // No lock ever: initial pulse plus MAX_RETRIES retries, then FAIL; restart recovers.
    pll_locked = 1'b0;
    do_reset();
    pulses = 0;
    run = 0;
    for (int i = 0; i < 60; i++) begin
      if (pll_rst === 1'b1) run++;
      else if (run > 0) begin
        check_eq("retry_pulse_len", run, RST_CYCLES);
        pulses++;
        run = 0;
      end
      step();
    end
    check_eq("retry_pulses", pulses, MAX_RETRIES + 1);
    check_eq("fail_state", state, 4);
    check_eq("fail_flag", fail, 1);
    check_eq("fail_vga_rst", vga_rst, 1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_eq("restart_state", state, 0);
    measure_pll_rst_run(run);
    check_eq("restart_pulse_len", run, RST_CYCLES);

    // Restart on the same edge as the final WAIT_LOCK timeout.
    do_reset();
    wl_entries = 0;
    prev_st = state;
    for (int i = 0; i < 100 && wl_entries < MAX_RETRIES + 1; i++) begin
      step();
      if (state === 3'd1 && prev_st !== 3'd1) wl_entries++;
      prev_st = state;
    end
    check_eq("wl_entries", wl_entries, MAX_RETRIES + 1);
    repeat (LOCK_TIMEOUT - 1) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_eq("restart_vs_timeout_state", state, 0);
    check_eq("restart_vs_timeout_fail", fail, 0);
    cyc = 0;
    for (int k = 0; k < 200 && state !== 3'd4; k++) begin
      step();
      cyc++;
    end
    check_eq("retries_cleared_cycles", cyc, (MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT));

    // One-cycle lock drop in RUN.
    do_reset();
    pll_locked = 1'b1;
    wait_state("reach_run", 3, 60);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    check_eq("drop_edge2_vga_rst", vga_rst, 0);
    step();
    check_eq("drop_edge3_vga_rst", vga_rst, 1);
    check_eq("drop_edge3_state", state, 0);
`ifdef VGA_PLL_CTRL_LOCK_LOSS_CNT_EN
    check_eq("drop_loss_cnt", lock_loss_cnt, 1);
`else
    check_eq("drop_loss_cnt", lock_loss_cnt, 0);
`endif

    // Lock glitch seen by the FSM at STABLE count 3.
    do_reset();
    pll_locked = 1'b1;
    wait_state("reach_stable", 2, 60);
    step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    step();
    check_eq("glitch_back_to_wait", state, 1);
    wait_state("restable", 2, 20);
    cyc = 0;
    for (int k = 0; k < 40 && state !== 3'd3; k++) begin
      step();
      cyc++;
    end
    check_eq("restable_to_run", cyc, STABLE_CYCLES);

    // 257 forced lock losses: counter saturates.
    do_reset();
    pll_locked = 1'b1;
    for (int n = 0; n < 257; n++) begin
      wait_state("loss_reach_run", 3, 60);
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      repeat (2) step();
    end
`ifdef VGA_PLL_CTRL_LOCK_LOSS_CNT_EN
    check_eq("loss_saturated", lock_loss_cnt, 255);
`else
    check_eq("loss_saturated", lock_loss_cnt, 0);
`endif

    // Random lock segments with occasional restart and reset.
    do_reset();
    run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        pll_locked = ($urandom_range(0, 2) != 0);
        run = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 50);
      end
      run--;
      restart = ($urandom_range(0, 99) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    restart = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
